// File: rtl/pipeline_pkg.sv
// Shared fetch/decode pipeline constants.
// The packet struct's field widths come from each module's parameters, so it is declared per module.
package pipeline_pkg;

    localparam int unsigned PC_WIDTH_DEFAULT    = 32;
    localparam int unsigned INSTR_WIDTH_DEFAULT = 32;
    localparam int unsigned QUEUE_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue with valid/ready handshakes and a flush input.
// Decode outputs are registered head contents, and they read as zero whenever the queue is empty.
module fetch_queue
    import pipeline_pkg::*;
#(
    parameter int unsigned PC_WIDTH          = PC_WIDTH_DEFAULT,
    parameter int unsigned INSTRUCTION_WIDTH = INSTR_WIDTH_DEFAULT,
    parameter int unsigned DEPTH             = QUEUE_DEPTH_DEFAULT
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         validF_i,
    output logic                         readyF_o,
    input  logic [PC_WIDTH-1:0]          PCF_i,
    input  logic [INSTRUCTION_WIDTH-1:0] InstrF_i,
    input  logic [PC_WIDTH-1:0]          PCPlus4F_i,
    input  logic                         predictTakenF_i,
    output logic                         validD_o,
    input  logic                         readyD_i,
    output logic [PC_WIDTH-1:0]          PCD_o,
    output logic [INSTRUCTION_WIDTH-1:0] InstrD_o,
    output logic [PC_WIDTH-1:0]          PCPlus4D_o,
    output logic                         predictTakenD_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PC_WIDTH-1:0]          pc;
        logic [INSTRUCTION_WIDTH-1:0] instr;
        logic [PC_WIDTH-1:0]          pcplus4;
        logic                         predict_taken;
    } fetch_pkt_t;

    fetch_pkt_t       mem [DEPTH];
    fetch_pkt_t       head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             clear;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign clear = !rst_ni || flush_i;
    // Acceptance depends only on occupancy, so a full queue refuses a packet even while it dequeues.
    assign push  = validF_i && !full && !clear;
    assign pop   = !empty && readyD_i && !clear;

    always_ff @(posedge clk_i) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    // Storage holds its contents through reset; only the pointers and count are cleared.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= '{pc: PCF_i, instr: InstrF_i, pcplus4: PCPlus4F_i,
                             predict_taken: predictTakenF_i};
        end
    end

    always_comb begin
        head = '0;
        if (!empty) head = mem[rd_ptr];
    end

    assign readyF_o        = !full;
    assign validD_o        = !empty;
    assign count_o         = count;
    assign PCD_o           = head.pc;
    assign InstrD_o        = head.instr;
    assign PCPlus4D_o      = head.pcplus4;
    assign predictTakenD_o = head.predict_taken;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a queue-based model is compared every cycle, and literal checks pin the key scenarios.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcp4;
        logic        pt;
    } pkt_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, validF, readyF, ptF, validD, readyD, ptD;
    logic [31:0] pcF, instrF, pcp4F, pcD, instrD, pcp4D;
    logic [2:0]  count;

    int unsigned checks = 0;
    int unsigned passed = 0;
    bit          model_live = 1'b0;
    bit          wrap_phase = 1'b0;
    int unsigned rx_idx = 0;
    pkt_t        mq[$];

    always #5 clk = ~clk;

    fetch_queue #(
        .PC_WIDTH(32),
        .INSTRUCTION_WIDTH(32),
        .DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .validF_i(validF), .readyF_o(readyF),
        .PCF_i(pcF), .InstrF_i(instrF), .PCPlus4F_i(pcp4F), .predictTakenF_i(ptF),
        .validD_o(validD), .readyD_i(readyD),
        .PCD_o(pcD), .InstrD_o(instrD), .PCPlus4D_o(pcp4D), .predictTakenD_o(ptD),
        .count_o(count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic pkt_t mk(input logic [31:0] pc);
        pkt_t p;
        p.pc    = pc;
        p.instr = 32'h0013_0000 | pc;
        p.pcp4  = pc + 32'd4;
        p.pt    = pc[2];
        return p;
    endfunction

    task automatic present(input bit v, input logic [31:0] pc);
        pkt_t p = mk(pc);
        validF = v;
        pcF    = p.pc;
        instrF = p.instr;
        pcp4F  = p.pcp4;
        ptF    = p.pt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: a plain FIFO of packets updated from the inputs seen at each rising edge.
    always @(posedge clk) begin
        bit do_push, do_pop;
        if (!rst_n || flush) begin
            mq.delete();
            if (!rst_n) model_live = 1'b1;
        end else begin
            do_push = validF && (mq.size() != DEPTH);
            do_pop  = readyD && (mq.size() != 0);
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(mk(pcF));
        end
    end

    // Compare process: mid-cycle, against the model's state after the last edge.
    always @(negedge clk) begin
        if (model_live) begin
            pkt_t e;
            bit   nonempty;
            nonempty = (mq.size() != 0);
            e = '{pc: 32'h0, instr: 32'h0, pcp4: 32'h0, pt: 1'b0};
            if (nonempty) e = mq[0];
            check("count",  64'(count),  64'(mq.size()));
            check("validD", 64'(validD), 64'(nonempty));
            check("readyF", 64'(readyF), 64'(mq.size() != DEPTH));
            check("PCD",    64'(pcD),    64'(e.pc));
            check("InstrD", 64'(instrD), 64'(e.instr));
            check("PCP4D",  64'(pcp4D),  64'(e.pcp4));
            check("ptD",    64'(ptD),    64'(e.pt));
            if (wrap_phase && validD && readyD) begin
                check("wrap_order", 64'(pcD), 64'(32'h100 + 32'(4 * rx_idx)));
                rx_idx++;
            end
        end
    end

    initial begin
        int unsigned k;
        int unsigned cyc;
        rst_n = 1'b0; flush = 1'b0; readyD = 1'b0;
        present(1'b1, 32'h80);

        // Reset held for two cycles with a packet presented
        step(); step();
        check("rst_count",  64'(count),  64'd0);
        check("rst_validD", 64'(validD), 64'd0);
        check("rst_readyF", 64'(readyF), 64'd1);
        check("rst_PCD",    64'(pcD),    64'd0);
        check("rst_InstrD", 64'(instrD), 64'd0);
        check("rst_ptD",    64'(ptD),    64'd0);

        // Streaming at one packet per cycle
        rst_n = 1'b1; readyD = 1'b1;
        present(1'b1, 32'h00); step();
        check("stream0_pc",  64'(pcD), 64'h00);
        check("stream0_cnt", 64'(count), 64'd1);
        present(1'b1, 32'h04); step();
        check("stream1_pc",  64'(pcD), 64'h04);
        check("stream1_cnt", 64'(count), 64'd1);
        present(1'b1, 32'h08); step();
        check("stream2_pc",  64'(pcD), 64'h08);
        check("stream2_ins", 64'(instrD), 64'h0013_0008);
        present(1'b0, 32'h0); step();
        check("drain_cnt", 64'(count), 64'd0);

        // Fill while decode stalls: the fifth packet is held off
        readyD = 1'b0;
        for (int i = 0; i < 5; i++) begin
            present(1'b1, 32'(4 * i)); step();
            if (i == 3) check("fill_readyF_after4", 64'(readyF), 64'd0);
        end
        check("fill_cnt",  64'(count), 64'd4);
        check("fill_head", 64'(pcD),   64'h00);
        step();
        check("full_hold_head", 64'(pcD), 64'h00);

        // Full with dequeue: nothing enters that cycle; the held packet enters next
        readyD = 1'b1; present(1'b1, 32'h50); step();
        check("fulldq_cnt",  64'(count), 64'd3);
        check("fulldq_head", 64'(pcD),   64'h04);
        readyD = 1'b0; step();
        check("refill_cnt",  64'(count), 64'd4);
        present(1'b0, 32'h0);

        // Drain, then build three entries and flush against an incoming packet
        readyD = 1'b1;
        for (int i = 0; i < 8 && count != 0; i++) step();
        check("predrain_cnt", 64'(count), 64'd0);
        readyD = 1'b0;
        for (int i = 0; i < 3; i++) begin
            present(1'b1, 32'h20 + 32'(4 * i)); step();
        end
        check("preflush_cnt", 64'(count), 64'd3);
        flush = 1'b1; present(1'b1, 32'h40); ptF = 1'b1; step();
        check("flush_cnt",    64'(count),  64'd0);
        check("flush_validD", 64'(validD), 64'd0);
        check("flush_ptD",    64'(ptD),    64'd0);
        flush = 1'b0; present(1'b0, 32'h0); step();
        check("postflush_cnt", 64'(count), 64'd0);

        // Wrap-around with random decode back-pressure
        wrap_phase = 1'b1; k = 0; cyc = 0;
        while (rx_idx < 10 && cyc < 200) begin
            present(k < 10, 32'h100 + 32'(4 * k));
            readyD = (k >= 10) ? 1'b1 : 1'($urandom_range(0, 1));
            @(posedge clk);
            if (validF && readyF) k++;
            #1;
            cyc++;
        end
        check("wrap_received", 64'(rx_idx), 64'd10);
        present(1'b0, 32'h0);
        step();
        check("wrap_end_cnt", 64'(count), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised fetch-to-decode instruction queue; the next generation of the fetch/decode pipeline register. It buffers up to DEPTH fetched packets (PC, instruction, PC+4, branch-prediction bit), so fetch keeps running while decode stalls. A valid/ready handshake on both sides replaces the single enable/clear pair, and a flush input empties the queue on redirect. It sits between the fetch stage and the decode stage.

## Interface
Parameters:
- PC_WIDTH, 32, width of PC and PC+4 fields
- INSTRUCTION_WIDTH, 32, width of instruction field
- DEPTH, 4, number of entries; power of two, at least 2

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_ni  in  1  reset; synchronous, active-low
- flush_i  in  1  discard all entries (branch mispredict or jump redirect)
- validF_i  in  1  fetch presents a packet this cycle
- readyF_o  out  1  queue accepts a packet this cycle; equals not full
- PCF_i  in  PC_WIDTH  fetch PC
- InstrF_i  in  INSTRUCTION_WIDTH  fetched instruction
- PCPlus4F_i  in  PC_WIDTH  fetch PC+4
- predictTakenF_i  in  1  predictor decision for this packet
- validD_o  out  1  head packet valid for decode
- readyD_i  in  1  decode consumes the head this cycle (not stalled)
- PCD_o  out  PC_WIDTH  head PC
- InstrD_o  out  INSTRUCTION_WIDTH  head instruction
- PCPlus4D_o  out  PC_WIDTH  head PC+4
- predictTakenD_o  out  1  head prediction bit
- count_o  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Enqueue occurs when validF_i and readyF_o are both high. The packet is written at the write pointer, and the write pointer advances.
- Dequeue occurs when validD_o and readyD_i are both high. The read pointer advances.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy is tracked in a separate counter of width $clog2(DEPTH+1).
- readyF_o = (count_o != DEPTH). It depends only on state, never on readyD_i. When full, no enqueue is accepted, even if a dequeue happens in the same cycle.
- validD_o = (count_o != 0).
- When validD_o is 0, all data outputs are driven to 0. A zero instruction is the bubble.
- Simultaneous enqueue and dequeue with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Dequeue when empty: ignored (validD_o is low).
- flush_i high: pointers and count go to 0 on the next edge. flush_i has priority over any enqueue or dequeue in the same cycle, so the incoming packet is dropped.
- Reset (rst_ni low) has the same effect as flush. Storage contents are not cleared.
- Reset or flush mid-stream leaves the queue empty, and validD_o is low on the next cycle.
- Reset values: validD_o=0, readyF_o=1, count_o=0, PCD_o=0, InstrD_o=0, PCPlus4D_o=0, predictTakenD_o=0.
- The predictTaken bit travels with its packet and is cleared by flush and reset. The predecessor design failed to clear it on freeze; this block must not repeat that.

## Timing
- Latency is 1 cycle. A packet enqueued at edge N is visible on the D outputs after edge N, provided the queue was empty or the packet becomes the head.
- Outputs are combinational reads of the registered head entry and count. There is no combinational path from validF_i or from any F data input to any D output.
- readyF_o and validD_o are functions of registered state only.
- Throughput is one packet per cycle in each direction while 0 < count < DEPTH.
- Queue full with decode stalled: head outputs hold stable across cycles and readyF_o stays low.

## Structure
- Shared package pipeline_pkg:
  - parameterised packed struct typedef fetch_pkt_t {pc, instr, pcplus4, predict_taken}
  - default width constants
- Storage: an array of DEPTH fetch_pkt_t inside the module.
- No sub-module. The pointer/count logic is small enough to stay inline.

## Test plan
- Reset: hold rst_ni=0 for 2 cycles with validF_i=1 -> count_o=0, validD_o=0, all D outputs 0, readyF_o=1.
- Streaming: enqueue PC 0x00, 0x04, 0x08 on consecutive cycles with readyD_i=1 -> D outputs show 0x00, 0x04, 0x08 one cycle later each; count_o stays at 1.
- Fill and stall: readyD_i=0, enqueue 5 packets with DEPTH=4 -> first 4 accepted, readyF_o=0 after the 4th, 5th held off; count_o=4; head stays at PC 0x00.
- Full with dequeue: with queue full, set readyD_i=1 and validF_i=1 -> no enqueue that cycle, count 4 -> 3; next cycle enqueue accepted and count returns to 4.
- Flush priority: 3 entries, then flush_i=1 with validF_i=1 (PC 0x40, predictTakenF_i=1) -> next cycle count_o=0, validD_o=0, predictTakenD_o=0, and 0x40 never appears.
- Wrap-around: push and pop 10 packets (PC 0x100 + 4k) with random readyD_i -> output order matches input order exactly across pointer wrap.
